// File: rtl/spi_pkg.sv
// Shared SPI definitions: chip-select mode encodings used by both the
// peripheral and the command sequencer, plus the sequencer state encoding.
package spi_pkg;

    // CSMode encodings understood by the SPI peripheral
    localparam logic [1:0] HOLDMODE = 2'b10;
    localparam logic [1:0] AUTOMODE = 2'b00;

    // Sequencer phases, in the order a transaction walks through them
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPCODE  = 3'd1,
        ADDR    = 3'd2,
        DUMMY   = 3'd3,
        DATA    = 3'd4,
        DRAIN   = 3'd5,
        RELEASE = 3'd6,
        DONE    = 3'd7
    } seqState_t;

    // Address byte counts above four behave as four
    function automatic logic [2:0] clampAddrBytes(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Bundle of every handshake and FIFO port around the SPI command sequencer.
// The slave modport is the sequencer; the master modport is the surrounding
// system (command client, data streams and SPI peripheral FIFOs).
interface spi_cmd_sequencer_if #(
    parameter int LENW = 8
);
    logic            CmdValid;
    logic            CmdReady;
    logic [7:0]      CmdOpcode;
    logic [31:0]     CmdAddr;
    logic [2:0]      CmdAddrBytes;
    logic [3:0]      CmdDummyBytes;
    logic            CmdDir;
    logic [LENW-1:0] CmdLen;
    logic [7:0]      WrData;
    logic            WrValid;
    logic            WrReady;
    logic [7:0]      RdData;
    logic            RdValid;
    logic            RdReady;
    logic [7:0]      TxData;
    logic            TxWrite;
    logic            TxFull;
    logic [7:0]      RxData;
    logic            RxRead;
    logic            RxEmpty;
    logic            SpiInactive;
    logic [1:0]      SpiCSMode;
    logic            Busy;
    logic            Done;

    modport slave (
        input  CmdValid, CmdOpcode, CmdAddr, CmdAddrBytes, CmdDummyBytes,
               CmdDir, CmdLen, WrData, WrValid, RdReady, TxFull, RxData,
               RxEmpty, SpiInactive,
        output CmdReady, WrReady, RdData, RdValid, TxData, TxWrite, RxRead,
               SpiCSMode, Busy, Done
    );

    modport master (
        output CmdValid, CmdOpcode, CmdAddr, CmdAddrBytes, CmdDummyBytes,
               CmdDir, CmdLen, WrData, WrValid, RdReady, TxFull, RxData,
               RxEmpty, SpiInactive,
        input  CmdReady, WrReady, RdData, RdValid, TxData, TxWrite, RxRead,
               SpiCSMode, Busy, Done
    );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: runs opcode/address/dummy/data transactions through
// the peripheral TX/RX FIFOs with CS held, discarding header RX bytes and
// forwarding read data. Outstanding bytes are credited against the RX FIFO
// depth so a stalled reader can never overflow the peripheral.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int FIFODEPTH = 8,
    parameter int LENW      = 8
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    spi_cmd_sequencer_if.slave bus
);
    localparam int OUTW = $clog2(FIFODEPTH + 1);
    localparam int RXW  = LENW + 1;
    localparam logic [OUTW-1:0] DEPTHCNT = OUTW'(FIFODEPTH);

    seqState_t       stateR;
    logic [7:0]      opcodeR;
    logic [31:0]     addrShiftR;
    logic [2:0]      addrBytesR;
    logic [3:0]      dummyBytesR;
    logic            dirR;
    logic [LENW-1:0] lenR;
    logic [LENW-1:0] phaseCntR;
    logic [OUTW-1:0] outstandingR;
    logic [RXW-1:0]  rxCountR;
    logic [1:0]      csModeR;

    logic            canPushS;
    logic            pushStateS;
    logic            wrPhaseS;
    logic            txWriteS;
    logic            lastPushS;
    logic            busyS;
    logic            discardS;
    logic            rxReadS;
    logic            acceptS;
    logic [LENW-1:0] phaseLenS;
    logic [7:0]      txDataS;
    logic [4:0]      headerS;
    logic [2:0]      abClampS;
    seqState_t       fromAddrS;
    seqState_t       fromDummyS;
    seqState_t       fromDataS;

    assign acceptS    = (stateR == IDLE) & bus.CmdValid;
    assign busyS      = (stateR != IDLE);
    assign abClampS   = clampAddrBytes(bus.CmdAddrBytes);
    assign canPushS   = ~bus.TxFull & (outstandingR < DEPTHCNT);
    assign wrPhaseS   = (stateR == DATA) & dirR;
    assign txWriteS   = pushStateS & canPushS & (~wrPhaseS | bus.WrValid);
    assign lastPushS  = txWriteS & (phaseCntR == (phaseLenS - LENW'(1)));
    assign headerS    = 5'd1 + 5'(addrBytesR) + 5'(dummyBytesR);
    assign discardS   = (rxCountR < RXW'(headerS)) | dirR;
    assign rxReadS    = ~bus.RxEmpty & busyS & (discardS | bus.RdReady);

    // Skip any phase whose byte count is zero
    assign fromDataS  = (lenR != '0) ? DATA : DRAIN;
    assign fromDummyS = (dummyBytesR != 4'd0) ? DUMMY : fromDataS;
    assign fromAddrS  = (addrBytesR != 3'd0) ? ADDR : fromDummyS;

    // Per-phase byte count, TX byte selection and push-state decode
    always_comb begin
        phaseLenS  = LENW'(1);
        txDataS    = 8'h00;
        pushStateS = 1'b0;
        case (stateR)
            OPCODE: begin
                pushStateS = 1'b1;
                txDataS    = opcodeR;
            end
            ADDR: begin
                pushStateS = 1'b1;
                phaseLenS  = LENW'(addrBytesR);
                txDataS    = addrShiftR[31:24];
            end
            DUMMY: begin
                pushStateS = 1'b1;
                phaseLenS  = LENW'(dummyBytesR);
            end
            DATA: begin
                pushStateS = 1'b1;
                phaseLenS  = lenR;
                txDataS    = dirR ? bus.WrData : 8'h00;
            end
            default: begin
                pushStateS = 1'b0;
            end
        endcase
    end

    // Command latch, phase sequencing and chip-select mode
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            stateR      <= IDLE;
            opcodeR     <= 8'h00;
            addrShiftR  <= 32'h0000_0000;
            addrBytesR  <= 3'd0;
            dummyBytesR <= 4'd0;
            dirR        <= 1'b0;
            lenR        <= '0;
            phaseCntR   <= '0;
            csModeR     <= AUTOMODE;
        end else begin
            case (stateR)
                IDLE: begin
                    if (acceptS) begin
                        opcodeR     <= bus.CmdOpcode;
                        // Left-align so the first address byte sits at [31:24]
                        addrShiftR  <= bus.CmdAddr << {3'd4 - abClampS, 3'b000};
                        addrBytesR  <= abClampS;
                        dummyBytesR <= bus.CmdDummyBytes;
                        dirR        <= bus.CmdDir;
                        lenR        <= bus.CmdLen;
                        phaseCntR   <= '0;
                        csModeR     <= HOLDMODE;
                        stateR      <= OPCODE;
                    end
                end
                OPCODE, ADDR, DUMMY, DATA: begin
                    if (txWriteS) begin
                        if (stateR == ADDR) begin
                            addrShiftR <= {addrShiftR[23:0], 8'h00};
                        end
                        if (lastPushS) begin
                            phaseCntR <= '0;
                            case (stateR)
                                OPCODE:  stateR <= fromAddrS;
                                ADDR:    stateR <= fromDummyS;
                                DUMMY:   stateR <= fromDataS;
                                default: stateR <= DRAIN;
                            endcase
                        end else begin
                            phaseCntR <= phaseCntR + LENW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (outstandingR == '0) begin
                        csModeR <= AUTOMODE;
                        stateR  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (bus.SpiInactive) begin
                        stateR <= DONE;
                    end
                end
                DONE: begin
                    stateR <= IDLE;
                end
                default: begin
                    stateR <= IDLE;
                end
            endcase
        end
    end

    // Credit counter: bytes pushed to TX whose RX byte has not been popped
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            outstandingR <= '0;
        end else begin
            case ({txWriteS, rxReadS})
                2'b10:   outstandingR <= outstandingR + OUTW'(1);
                2'b01:   outstandingR <= (outstandingR != '0) ? outstandingR - OUTW'(1) : outstandingR;
                default: outstandingR <= outstandingR;
            endcase
        end
    end

    // Popped RX byte index within the current transaction
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rxCountR <= '0;
        end else if (acceptS) begin
            rxCountR <= '0;
        end else if (rxReadS) begin
            rxCountR <= rxCountR + RXW'(1);
        end else begin
            rxCountR <= rxCountR;
        end
    end

    assign bus.CmdReady  = (stateR == IDLE);
    assign bus.Busy      = busyS;
    assign bus.Done      = (stateR == DONE);
    assign bus.SpiCSMode = csModeR;
    assign bus.TxWrite   = txWriteS;
    assign bus.TxData    = txDataS;
    assign bus.WrReady   = wrPhaseS & canPushS;
    assign bus.RxRead    = rxReadS;
    assign bus.RdValid   = ~bus.RxEmpty & busyS & ~discardS;
    assign bus.RdData    = bus.RxData;

endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Hardware command sequencer that drives the SPI peripheral's transmit/receive FIFOs and chip-select mode to run complete flash-style transactions (opcode, address, dummy, data) without software byte-pushing. It sits between a command/data-stream client (boot loader or DMA) and the SPI peripheral's FIFO and CSMode inputs. It holds CS asserted across all phases, discards header RX bytes, forwards read data, and releases CS at the end.

## Interface
- FIFODEPTH, 8, depth of the peripheral RX FIFO; caps the number of outstanding (pushed-but-not-popped) bytes
- LENW, 8, width of data-phase byte count
- PCLK  in  1  clock
- PRESETn  in  1  reset, asynchronous, active-low
- CmdValid / CmdReady  in / out  1  command handshake
- CmdOpcode  in  8  opcode byte
- CmdAddr  in  32  address, sent MSB-first
- CmdAddrBytes  in  3  address bytes 0–4; values >4 treated as 4
- CmdDummyBytes  in  4  dummy 0x00 bytes, 0–15
- CmdDir  in  1  0 = read, 1 = write
- CmdLen  in  LENW  data-phase bytes; 0 = no data phase
- WrData / WrValid / WrReady  in / in / out  8/1/1  write-data stream
- RdData / RdValid / RdReady  out / out / in  8/1/1  read-data stream
- TxData / TxWrite / TxFull  out / out / in  8/1/1  peripheral TX FIFO write port
- RxData / RxRead / RxEmpty  in / out / in  8/1/1  peripheral RX FIFO read port
- SpiInactive  in  1  peripheral controller is in its inactive state
- SpiCSMode  out  2  drives peripheral CSMode: 2'b10 HOLD, 2'b00 AUTO
- Busy  out  1  state != IDLE
- Done  out  1  one-cycle pulse at transaction end

## Operation
- Fields are latched on CmdValid & CmdReady. CmdReady = (state == IDLE).
- States and transitions:
  - IDLE: on accept, set SpiCSMode = HOLD and go to OPCODE.
  - OPCODE: push CmdOpcode, then go to ADDR if AddrBytes > 0, else DUMMY if DummyBytes > 0, else DATA if Len > 0, else DRAIN.
  - ADDR: push CmdAddr[8k-1 -: 8] for k = AddrBytes down to 1, then skip empty phases as above.
  - DUMMY: push 0x00 DummyBytes times.
  - DATA:
    - Write: push WrData. WrReady = DATA & CmdDir & CanPush.
    - Read: push 0x00 filler.
    - Len pushes, then go to DRAIN.
  - DRAIN: wait until Outstanding == 0, then set SpiCSMode = AUTO and go to RELEASE.
  - RELEASE: wait for SpiInactive, then go to DONE.
  - DONE: Done = 1, then go to IDLE.
- CanPush = ~TxFull & (Outstanding < FIFODEPTH). TxWrite = push-state & CanPush, and additionally & WrValid in write DATA. At most one byte per cycle.
- Outstanding increments on TxWrite and decrements on RxRead; both in the same cycle leaves it unchanged.
- RX steering:
  - RxCount counts popped bytes. Header = 1 + AddrBytes + DummyBytes.
  - A popped byte is discarded if RxCount < Header or CmdDir = 1.
  - Otherwise it is presented: RdValid = ~RxEmpty & ~discard, RdData = RxData.
  - RxRead = ~RxEmpty & Busy & (discard | RdReady).
- Arithmetic: Header fits 5 bits (max 20). Compare RxCount (LENW+1 bits) against Header + Len without overflow.
- Reset values: SpiCSMode 2'b00, Busy 0, Done 0, TxWrite 0, RxRead 0, RdValid 0, WrReady 0, CmdReady 1. All counters clear.
- Reset mid-transaction returns to IDLE with SpiCSMode AUTO. FIFO contents are not flushed; flushing is the integrator's responsibility.
- RX bytes arriving while IDLE are never popped.

## Timing
- The OPCODE push can occur the cycle after acceptance. Minimum latency from accept to first TxWrite is 1 cycle.
- Back-to-back pushes are allowed every cycle while CanPush holds.
- Done is asserted exactly 1 cycle after SpiInactive is seen in RELEASE. CmdReady rises the cycle after Done.
- SpiCSMode changes only on the IDLE→OPCODE and DRAIN→RELEASE transitions. It is registered.
- RdData/RdValid are combinational from the RX port (zero latency).
- A stalled RdReady backpressures to TX through Outstanding: TX stops after FIFODEPTH unread bytes.

## Structure
- Shared package spi_pkg holds:
  - the CS mode constants HOLDMODE = 2'b10 and AUTOMODE = 2'b00, shared with the SPI peripheral;
  - the sequencer state enum {IDLE, OPCODE, ADDR, DUMMY, DATA, DRAIN, RELEASE, DONE}.
- Single module, no sub-modules. The Outstanding credit counter and the phase byte counter are inline.

## Test plan
- Read 0x03, addr 0x00123456, 3 addr bytes, 0 dummy, Len 4: TX = 03 12 34 56 00 00 00 00; first 4 RX discarded, next 4 forwarded in order; SpiCSMode 10→00; one Done pulse.
- Write 0x02, 4 addr bytes 0xDEADBEEF, Len 2 with WrData A5, 5A: TX = 02 DE AD BE EF A5 5A; no RdValid; WrValid held low 5 cycles stalls TX with no byte lost.
- Opcode-only 0x06 (0 addr, 0 dummy, Len 0): exactly one TX byte; DRAIN → RELEASE → DONE; Done within 1 cycle of SpiInactive.
- Read with 8 dummy, Len 16, RdReady = 0 throughout: TxWrite stops once Outstanding = 8; releasing RdReady completes with all 16 bytes delivered.
- TxFull asserted for 10 cycles mid-ADDR: no TxWrite during those cycles; byte order preserved.
- PRESETn pulsed low during DATA: all outputs at reset values asynchronously; CmdReady = 1 on the next PCLK; the next command runs normally.
